// File: rtl/sipo_framed_pkg.sv
// Shared helpers for the framed serial-in/parallel-out shifter: beat count,
// counter width and the lane/width legality check.
package sipo_pkg;

    function automatic int beats(input int bits, input int lanes);
        return bits / lanes;
    endfunction

    // Count must be able to hold 0..BEATS-1, but keep at least one bit for BEATS=1.
    function automatic int cnt_w(input int n_beats);
        return (n_beats < 1) ? 1 : $clog2(n_beats + 1);
    endfunction

    function automatic bit lanes_ok(input int bits, input int lanes);
        return (lanes >= 1) && (bits >= lanes) && ((bits % lanes) == 0);
    endfunction

endpackage

// File: rtl/sipo_framed_if.sv
// Chunk input / word output bundle for sipo_framed. The design sits on the
// slave side; the chunk producer and word consumer share the master side.
interface sipo_framed_if #(
    parameter int BITS  = 8,
    parameter int LANES = 1,
    parameter int CW    = $clog2(BITS / LANES + 1)
);
    logic [LANES-1:0] in_serial;
    logic             in_valid;
    logic             in_sync;
    logic             in_ready;
    logic [BITS-1:0]  out_parallel;
    logic             out_valid;
    logic             out_overflow;
    logic [CW-1:0]    out_count;

    modport slave (
        input  in_serial, in_valid, in_sync, in_ready,
        output out_parallel, out_valid, out_overflow, out_count
    );

    modport master (
        output in_serial, in_valid, in_sync, in_ready,
        input  out_parallel, out_valid, out_overflow, out_count
    );
endinterface

// File: rtl/sipo_framed_chunk_shift.sv
// Chunked shift register with enable and clear. word is the value the
// register takes at the next edge, so a completing beat can be captured directly.
module sipo_chunk_shift #(
    parameter int BITS        = 8,
    parameter int LANES       = 1,
    parameter bit SHIFT_RIGHT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [LANES-1:0] din,
    output logic [BITS-1:0]  word
);
    logic [BITS-1:0] sreg;
    logic [BITS-1:0] base;
    logic [BITS-1:0] shifted;

    // Clear applies before the shift, so a chunk arriving with clr lands in a zeroed register.
    assign base = clr ? '0 : sreg;

    generate
        if (BITS == LANES) begin : g_whole
            assign shifted = din;
        end else if (SHIFT_RIGHT) begin : g_right
            assign shifted = {din, base[BITS-1:LANES]};
        end else begin : g_left
            assign shifted = {base[BITS-LANES-1:0], din};
        end
    endgenerate

    assign word = en ? shifted : base;

    always_ff @(posedge clk) begin
        if (rst) sreg <= '0;
        else     sreg <= word;
    end
endmodule

// File: rtl/sipo_framed.sv
// Framed SIPO: shifts LANES bits per strobe, frames BITS-wide words by beat
// count and hands them out through a registered valid/ready with sticky overflow.
module sipo_framed
    import sipo_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int LANES       = 1,
    parameter bit SHIFT_RIGHT = 1'b1
) (
    input  logic          in_clk,
    input  logic          in_rst,
    sipo_framed_if.slave  bus
);
    localparam int BEATS = beats(BITS, LANES);
    localparam int CW    = cnt_w(BEATS);

    generate
        if (!lanes_ok(BITS, LANES)) begin : g_bad_params
            $error("sipo_framed: BITS must be a non-zero multiple of LANES");
        end
    endgenerate

    logic [CW-1:0]   count;
    logic [CW-1:0]   cnt_base;
    logic [CW-1:0]   cnt_nxt;
    logic [BITS-1:0] word;
    logic            complete;
    logic            can_load;

    logic [BITS-1:0] par_q;
    logic            vld_q;
    logic            ovf_q;

    sipo_chunk_shift #(
        .BITS        (BITS),
        .LANES       (LANES),
        .SHIFT_RIGHT (SHIFT_RIGHT)
    ) u_shift (
        .clk  (in_clk),
        .rst  (in_rst),
        .en   (bus.in_valid),
        .clr  (bus.in_sync),
        .din  (bus.in_serial),
        .word (word)
    );

    // A sync restarts the frame, so the chunk arriving with it is beat 0.
    always_comb begin
        cnt_base = bus.in_sync ? '0 : count;
        complete = bus.in_valid && (cnt_base == CW'(BEATS - 1));
        cnt_nxt  = cnt_base;
        if (bus.in_valid)
            cnt_nxt = complete ? '0 : cnt_base + 1'b1;
    end

    // The holding register is free if empty or being drained this edge.
    assign can_load = !vld_q || bus.in_ready;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            count <= '0;
            par_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            count <= cnt_nxt;
            if (complete) begin
                if (can_load) begin
                    par_q <= word;
                    vld_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (vld_q && bus.in_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.out_parallel = par_q;
    assign bus.out_valid    = vld_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_count    = count;
endmodule
